// File: rtl/usbf_pkg.sv
// Shared definitions for the USB function buffer RAM: clear-sequencer state
// encoding and byte-lane width.
package usbf_pkg;

  localparam int USBF_BYTE_W = 8;

  typedef enum logic {
    USBF_RAM_IDLE  = 1'b0,
    USBF_RAM_CLEAR = 1'b1
  } usbf_ram_state_e;

endpackage

// File: rtl/usbf_ram_clr.sv
// Post-reset clear sequencer: walks every word address once, writing zero,
// then idles until the next reset. Built only with USBF_DPRAM_CLEAR_EN.
module usbf_ram_clr
  import usbf_pkg::*;
#(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          rst,
  output logic          busy,
  output logic [AW-1:0] clr_addr,
  output logic          clr_we
);

  localparam logic [AW-1:0] LAST_ADDR = '1;

  usbf_ram_state_e state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= USBF_RAM_CLEAR;
      clr_addr <= '0;
    end else if (state == USBF_RAM_CLEAR) begin
      // The last word is written on this edge; the address parks there.
      if (clr_addr == LAST_ADDR) begin
        state <= USBF_RAM_IDLE;
      end else begin
        clr_addr <= clr_addr + 1'b1;
      end
    end
  end

  // With a 1-bit state encoding, busy is the state itself.
  assign busy   = (state == USBF_RAM_CLEAR);
  assign clr_we = busy;

endmodule

// File: rtl/usbf_dpram.sv
// Simple-dual-port buffer RAM with byte enables, write-first forwarding and
// an optional output register. USBF_DPRAM_CLEAR_EN adds a post-reset zero fill.
module usbf_dpram
  import usbf_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 15,
  parameter int OUT_REG = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_en_i,
  input  logic [AW-1:0]      wr_addr_i,
  input  logic [DW-1:0]      wr_data_i,
  input  logic [DW/8-1:0]    wr_be_i,
  input  logic               rd_en_i,
  input  logic [AW-1:0]      rd_addr_i,
  output logic [DW-1:0]      rd_data_o,
  output logic               rd_valid_o,
  output logic               init_busy_o
);

  localparam int NB    = DW / USBF_BYTE_W;
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  logic          busy;
  logic          clr_we;
  logic [AW-1:0] clr_addr;

`ifdef USBF_DPRAM_CLEAR_EN
  usbf_ram_clr #(.AW(AW)) u_clr (
    .clk      (clk_i),
    .rst      (rst_i),
    .busy     (busy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );
`else
  assign busy     = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  assign init_busy_o = busy;

  logic wr_fire;
  logic rd_fire;

  assign wr_fire = wr_en_i & ~busy & ~rst_i;
  assign rd_fire = rd_en_i & ~busy;

  // Array write: the clear sequencer owns the port while busy.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_fire) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be_i[b]) begin
          mem[wr_addr_i][b*USBF_BYTE_W +: USBF_BYTE_W] <= wr_data_i[b*USBF_BYTE_W +: USBF_BYTE_W];
        end
      end
    end
  end

  // Write-first: a same-address write replaces the enabled bytes of the
  // word being read in this cycle.
  logic [DW-1:0] rd_word;

  always_comb begin
    rd_word = mem[rd_addr_i];
    for (int b = 0; b < NB; b++) begin
      if (wr_fire && (wr_addr_i == rd_addr_i) && wr_be_i[b]) begin
        rd_word[b*USBF_BYTE_W +: USBF_BYTE_W] = wr_data_i[b*USBF_BYTE_W +: USBF_BYTE_W];
      end
    end
  end

  // rd_valid_o is a one-cycle pulse per accepted read; there is no
  // back-pressure, so data must be taken in the cycle valid is high.
  logic [DW-1:0] s1_data;
  logic          s1_valid;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= rd_fire;
      if (rd_fire) begin
        s1_data <= rd_word;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DW-1:0] s2_data;
      logic          s2_valid;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign rd_data_o  = s2_data;
      assign rd_valid_o = s2_valid;
    end else begin : g_no_out_reg
      assign rd_data_o  = s1_data;
      assign rd_valid_o = s1_valid;
    end
  endgenerate

endmodule

// File: tb/tb_usbf_dpram.sv
// Directed bench for usbf_dpram: two instances (latency 1 and latency 2)
// share one stimulus stream; clear checks apply when USBF_DPRAM_CLEAR_EN is set.
module tb_usbf_dpram;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
`ifdef USBF_DPRAM_CLEAR_EN
  localparam bit EXP_BUSY = 1'b1;
`else
  localparam bit EXP_BUSY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [3:0]    wr_be = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  logic [DW-1:0] rd_data0, rd_data1;
  logic          rd_valid0, rd_valid1;
  logic          busy0, busy1;

  int tests = 0;
  int fails = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  usbf_dpram #(.DW(DW), .AW(AW), .OUT_REG(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data0), .rd_valid_o(rd_valid0), .init_busy_o(busy0)
  );

  usbf_dpram #(.DW(DW), .AW(AW), .OUT_REG(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data1), .rd_valid_o(rd_valid1), .init_busy_o(busy1)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

`ifdef USBF_DPRAM_CLEAR_EN
  // Runs the clear window just after rst falls, poking both ports throughout.
  task automatic run_clear_window(input string tag);
    int cnt;
    cnt = 0;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd5;
    while (busy0 && cnt < 100) begin
      tests++;
      if (rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0) begin
        fails++;
        $display("FAIL %s valid_while_busy: got %b/%b required 0/0", tag, rd_valid0, rd_valid1);
      end
      cnt++;
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b0;
    tests++;
    if (cnt != DEPTH) begin
      fails++;
      $display("FAIL %s busy_cycles: got %0d required %0d", tag, cnt, DEPTH);
    end
  endtask
`endif

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if (rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid: got %b/%b required 0/0", rd_valid0, rd_valid1);
    end
    tests++;
    if (rd_data0 !== 32'h0 || rd_data1 !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: got %h/%h required 0/0", rd_data0, rd_data1);
    end
    tests++;
    if (busy0 !== EXP_BUSY || busy1 !== EXP_BUSY) begin
      fails++;
      $display("FAIL reset_busy: got %b/%b required %b", busy0, busy1, EXP_BUSY);
    end
    rst = 1'b0;
`ifdef USBF_DPRAM_CLEAR_EN
    run_clear_window("reset");
    rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    rd_en = 1'b0;
    tests++;
    if (rd_valid0 !== 1'b1 || rd_data0 !== 32'h0) begin
      fails++;
      $display("FAIL cleared_addr5: got v=%b d=%h required v=1 d=00000000", rd_valid0, rd_data0);
    end
`else
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (busy0 !== 1'b0) begin
        fails++;
        $display("FAIL no_clear_busy: got %b required 0", busy0);
      end
    end
`endif
  endtask

  task automatic test_byte_enable();
    write_word(4'd3, 32'hDEAD_BEEF, 4'b1111);
    write_word(4'd3, 32'h1122_3344, 4'b0101);
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    rd_en = 1'b0;
    tests++;
    if (rd_valid0 !== 1'b1 || rd_data0 !== 32'hDE22_BE44) begin
      fails++;
      $display("FAIL be_merge_l1: got v=%b d=%h required v=1 d=de22be44", rd_valid0, rd_data0);
    end
    tests++;
    if (rd_valid1 !== 1'b0) begin
      fails++;
      $display("FAIL be_merge_l2_early: got v=%b required 0", rd_valid1);
    end
    tick();
    tests++;
    if (rd_valid1 !== 1'b1 || rd_data1 !== 32'hDE22_BE44) begin
      fails++;
      $display("FAIL be_merge_l2: got v=%b d=%h required v=1 d=de22be44", rd_valid1, rd_data1);
    end
    tests++;
    if (rd_valid0 !== 1'b0 || rd_data0 !== 32'hDE22_BE44) begin
      fails++;
      $display("FAIL hold_l1: got v=%b d=%h required v=0 d=de22be44", rd_valid0, rd_data0);
    end
  endtask

  task automatic test_wr_be_zero();
    write_word(4'd3, 32'h0000_0000, 4'b0000);
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    rd_en = 1'b0;
    tests++;
    if (rd_data0 !== 32'hDE22_BE44) begin
      fails++;
      $display("FAIL be_zero_noop: got %h required de22be44", rd_data0);
    end
  endtask

  task automatic test_forward();
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hCAFE_F00D; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd7;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    tests++;
    if (rd_valid0 !== 1'b1 || rd_data0 !== 32'hCAFE_F00D) begin
      fails++;
      $display("FAIL fwd_full_l1: got v=%b d=%h required v=1 d=cafef00d", rd_valid0, rd_data0);
    end
    tick();
    tests++;
    if (rd_valid1 !== 1'b1 || rd_data1 !== 32'hCAFE_F00D) begin
      fails++;
      $display("FAIL fwd_full_l2: got v=%b d=%h required v=1 d=cafef00d", rd_valid1, rd_data1);
    end
    // Partial forward: only the top byte is replaced.
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hAABB_CCDD; wr_be = 4'b1000;
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    tests++;
    if (rd_data0 !== 32'hAA22_BE44) begin
      fails++;
      $display("FAIL fwd_partial_l1: got %h required aa22be44", rd_data0);
    end
    tick();
    tests++;
    if (rd_data1 !== 32'hAA22_BE44) begin
      fails++;
      $display("FAIL fwd_partial_l2: got %h required aa22be44", rd_data1);
    end
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    rd_en = 1'b0;
    tests++;
    if (rd_data0 !== 32'hAA22_BE44) begin
      fails++;
      $display("FAIL fwd_written_back: got %h required aa22be44", rd_data0);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d [3];
    int            v1_cnt;
    exp_d[0] = 32'h0102_0304;
    exp_d[1] = 32'hA5A5_5A5A;
    exp_d[2] = 32'h8000_0001;
    for (int i = 0; i < 3; i++) write_word(AW'(i), exp_d[i], 4'hF);
    v1_cnt = 0;
    for (int t = 0; t < 5; t++) begin
      rd_en   = (t < 3);
      rd_addr = AW'((t < 3) ? t : 0);
      wr_en   = (t == 0);
      wr_addr = 4'd15; wr_data = 32'h0F0F_0F0F; wr_be = 4'hF;
      tick();
      tests++;
      if (rd_valid0 !== (t < 3) || rd_data0 !== exp_d[(t < 3) ? t : 2]) begin
        fails++;
        $display("FAIL b2b_l1 t=%0d: got v=%b d=%h required v=%b d=%h", t, rd_valid0, rd_data0,
                 (t < 3), exp_d[(t < 3) ? t : 2]);
      end
      if (rd_valid1 === 1'b1) v1_cnt++;
      if (t >= 1) begin
        tests++;
        if (rd_valid1 !== (t <= 3) || rd_data1 !== exp_d[(t <= 3) ? t - 1 : 2]) begin
          fails++;
          $display("FAIL b2b_l2 t=%0d: got v=%b d=%h required v=%b d=%h", t, rd_valid1, rd_data1,
                   (t <= 3), exp_d[(t <= 3) ? t - 1 : 2]);
        end
      end
    end
    rd_en = 1'b0; wr_en = 1'b0;
    tests++;
    if (v1_cnt != 3) begin
      fails++;
      $display("FAIL b2b_l2_pulses: got %0d required 3", v1_cnt);
    end
    rd_en = 1'b1; rd_addr = 4'd15;
    tick();
    rd_en = 1'b0;
    tests++;
    if (rd_data0 !== 32'h0F0F_0F0F) begin
      fails++;
      $display("FAIL independent_write: got %h required 0f0f0f0f", rd_data0);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    // Read and reset sampled on the same edge: the read is dropped.
    rd_en = 1'b1; rd_addr = 4'd3; rst = 1'b1;
    tick();
    rd_en = 1'b0;
    tests++;
    if (rd_valid0 !== 1'b0 || rd_data0 !== 32'h0) begin
      fails++;
      $display("FAIL rst_same_edge_l1: got v=%b d=%h required v=0 d=0", rd_valid0, rd_data0);
    end
    tick();
    tests++;
    if (rd_valid1 !== 1'b0 || rd_data1 !== 32'h0) begin
      fails++;
      $display("FAIL rst_same_edge_l2: got v=%b d=%h required v=0 d=0", rd_valid1, rd_data1);
    end
    rst = 1'b0;
`ifdef USBF_DPRAM_CLEAR_EN
    run_clear_window("rst_read_a");
`endif
    // Reset one edge after the read: the latency-2 result never appears.
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    rd_en = 1'b0; rst = 1'b1;
    tick();
    tests++;
    if (rd_valid1 !== 1'b0 || rd_data1 !== 32'h0) begin
      fails++;
      $display("FAIL rst_pending_l2: got v=%b d=%h required v=0 d=0", rd_valid1, rd_data1);
    end
    tests++;
    if (rd_valid0 !== 1'b0 || rd_data0 !== 32'h0) begin
      fails++;
      $display("FAIL rst_pending_l1: got v=%b d=%h required v=0 d=0", rd_valid0, rd_data0);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (rd_valid1 !== 1'b0) begin
      fails++;
      $display("FAIL rst_pending_l2_late: got v=%b required 0", rd_valid1);
    end
`ifdef USBF_DPRAM_CLEAR_EN
    run_clear_window("rst_read_b");
`endif
  endtask

`ifdef USBF_DPRAM_CLEAR_EN
  task automatic test_reset_mid_clear();
    write_word(4'd9, 32'h1234_5678, 4'hF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    tests++;
    if (busy0 !== 1'b1) begin
      fails++;
      $display("FAIL mid_clear_busy: got %b required 1", busy0);
    end
    rst = 1'b0;
    run_clear_window("mid_clear");
    rd_en = 1'b1; rd_addr = 4'd9;
    tick();
    rd_en = 1'b0;
    tests++;
    if (rd_valid0 !== 1'b1 || rd_data0 !== 32'h0) begin
      fails++;
      $display("FAIL mid_clear_addr9: got v=%b d=%h required v=1 d=0", rd_valid0, rd_data0);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_byte_enable();
    test_wr_be_zero();
    test_forward();
    test_back_to_back();
    test_reset_mid_read();
`ifdef USBF_DPRAM_CLEAR_EN
    test_reset_mid_clear();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
